// File: rtl/dmp_ordered_stream.sv
// Ordered beat streamer: waits until every participating gather thread is done, then
// streams each enabled thread's values LANES at a time, in thread/node order.
module dmp_ordered_stream #(
  parameter int NUM_HW_THREADS = 8,
  parameter int NODES_IN_GRAPH = 32,
  parameter int DATA_W         = 64,
  parameter int LANES          = 8,
  localparam int TID_W  = (NUM_HW_THREADS > 1) ? $clog2(NUM_HW_THREADS) : 1,
  localparam int NODE_W = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1
) (
  input  logic                                            clock,
  input  logic                                            reset_n,
  input  logic                                            next_iteration,
  input  logic [NUM_HW_THREADS-1:0]                       thread_enable,
  input  logic [NUM_HW_THREADS-1:0]                       gather_done,
  input  logic [NUM_HW_THREADS*NODES_IN_GRAPH*DATA_W-1:0] gather_data,
  output logic [LANES*DATA_W-1:0]                         out_data,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic                                            out_sop,
  output logic                                            out_eop,
  output logic [TID_W-1:0]                                out_thread_id,
  output logic [NODE_W-1:0]                               out_node_base,
  output logic                                            stream_done,
  output logic [31:0]                                     iteration_count,
  output logic [1:0]                                      state_dbg
);

  if (NODES_IN_GRAPH % LANES != 0) begin : g_bad_lanes
    $error("NODES_IN_GRAPH must be an integer multiple of LANES");
  end

  // Handshake: a beat transfers on a rising edge where out_valid && out_ready; while
  // out_valid is high and out_ready low, every beat field holds its value unchanged.

  typedef enum logic [1:0] {
    WAIT_FOR_THREADS = 2'd0,
    SEND             = 2'd1,
    END              = 2'd2
  } state_t;

  state_t                    state, state_nxt;
  logic [NUM_HW_THREADS-1:0] done_mask;
  logic [NUM_HW_THREADS-1:0] en_mask, en_nxt;
  logic [TID_W-1:0]          thr_ptr, thr_nxt;
  logic [NODE_W-1:0]         node_ptr, node_nxt;
  logic                      first_beat, first_nxt;
  logic [TID_W-1:0]          last_thr;
  logic [TID_W-1:0]          next_thr;
  logic                      last_node;
  logic                      is_last;
  logic                      all_ready;

  function automatic logic [TID_W-1:0] lowest_en(input logic [NUM_HW_THREADS-1:0] en);
    lowest_en = '0;
    for (int i = NUM_HW_THREADS - 1; i >= 0; i--) begin
      if (en[i]) lowest_en = TID_W'(i);
    end
  endfunction

  function automatic logic [TID_W-1:0] highest_en(input logic [NUM_HW_THREADS-1:0] en);
    highest_en = '0;
    for (int i = 0; i < NUM_HW_THREADS; i++) begin
      if (en[i]) highest_en = TID_W'(i);
    end
  endfunction

  // Nearest enabled thread above cur, so disabled threads cost no idle cycle.
  function automatic logic [TID_W-1:0] next_en(input logic [NUM_HW_THREADS-1:0] en,
                                               input logic [TID_W-1:0]          cur);
    next_en = cur;
    for (int i = NUM_HW_THREADS - 1; i >= 0; i--) begin
      if (en[i] && (i > int'(cur))) next_en = TID_W'(i);
    end
  endfunction

  assign all_ready = &(done_mask | ~thread_enable);
  assign last_thr  = highest_en(en_mask);
  assign next_thr  = next_en(en_mask, thr_ptr);
  assign last_node = (node_ptr == NODE_W'(NODES_IN_GRAPH - LANES));
  assign is_last   = last_node && (thr_ptr == last_thr);
  assign state_dbg = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT_FOR_THREADS;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    thr_nxt     = thr_ptr;
    node_nxt    = node_ptr;
    first_nxt   = first_beat;
    en_nxt      = en_mask;
    out_valid   = 1'b0;
    out_sop     = 1'b0;
    out_eop     = 1'b0;
    stream_done = 1'b0;

    case (state)
      WAIT_FOR_THREADS: begin
        if (all_ready) begin
          if (|thread_enable) begin
            state_nxt = SEND;
            en_nxt    = thread_enable;
            thr_nxt   = lowest_en(thread_enable);
            node_nxt  = '0;
            first_nxt = 1'b1;
          end else begin
            state_nxt = END;
          end
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_sop   = first_beat;
        out_eop   = is_last;
        if (out_ready) begin
          first_nxt = 1'b0;
          if (is_last) begin
            state_nxt = END;
          end else if (last_node) begin
            node_nxt = '0;
            thr_nxt  = next_thr;
          end else begin
            node_nxt = node_ptr + NODE_W'(LANES);
          end
        end
      end
      END: begin
        stream_done = 1'b1;
      end
      default: begin
        state_nxt = WAIT_FOR_THREADS;
      end
    endcase

    // A new iteration aborts whatever is in flight, without an eop.
    if (next_iteration) begin
      state_nxt = WAIT_FOR_THREADS;
      thr_nxt   = '0;
      node_nxt  = '0;
      first_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_mask       <= '0;
      en_mask         <= '0;
      thr_ptr         <= '0;
      node_ptr        <= '0;
      first_beat      <= 1'b0;
      iteration_count <= '0;
    end else begin
      thr_ptr    <= thr_nxt;
      node_ptr   <= node_nxt;
      first_beat <= first_nxt;
      en_mask    <= en_nxt;
      if (next_iteration) begin
        done_mask <= '0;
        if (state == END) iteration_count <= iteration_count + 32'd1;
      end else begin
        done_mask <= done_mask | gather_done;
      end
    end
  end

  // Beat fields read as zero whenever no beat is being offered.
  always_comb begin
    out_data      = '0;
    out_thread_id = '0;
    out_node_base = '0;
    if (state == SEND) begin
      out_thread_id = thr_ptr;
      out_node_base = node_ptr;
      for (int k = 0; k < LANES; k++) begin
        out_data[k*DATA_W +: DATA_W] =
          gather_data[(int'(thr_ptr)*NODES_IN_GRAPH + int'(node_ptr) + k)*DATA_W +: DATA_W];
      end
    end
  end

endmodule
